// File: rtl/inc_pkg.sv
// Shared types and widths for the pitch/yaw integrators.
package inc_pkg;

    typedef enum logic [1:0] {SETTLE, CAL, RUN} state_e;

    localparam int INTEG_W = 27;
    localparam int INC_W   = 13;
    localparam int RATE_W  = 16;

    localparam logic signed [INTEG_W-1:0] INTEG_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
    localparam logic signed [INTEG_W-1:0] INTEG_MIN = {1'b1, {(INTEG_W-1){1'b0}}};

endpackage

// File: rtl/sat_add27.sv
// Three-operand signed add that clamps to the integrator range instead of wrapping.
module sat_add27
    import inc_pkg::*;
(
    input  logic signed [INTEG_W-1:0] a_i,
    input  logic signed [INTEG_W-1:0] b_i,
    input  logic signed [INTEG_W-1:0] c_i,
    output logic signed [INTEG_W-1:0] y_o
);

    // Two guard bits hold the worst case of three full-range operands.
    localparam int SW = INTEG_W + 2;
    localparam logic signed [SW-1:0] MAX_X = SW'(INTEG_MAX);
    localparam logic signed [SW-1:0] MIN_X = SW'(INTEG_MIN);

    logic signed [SW-1:0] sum;

    assign sum = SW'(a_i) + SW'(b_i) + SW'(c_i);

    always_comb begin
        y_o = sum[INTEG_W-1:0];
        if (sum > MAX_X)      y_o = INTEG_MAX;
        else if (sum < MIN_X) y_o = INTEG_MIN;
    end

endmodule

// File: rtl/incline_integrator.sv
// Gyro pitch integrator with post-reset offset calibration and fixed-step accel correction.
module incline_integrator
    import inc_pkg::*;
#(
    parameter int SETTLE_CYC  = 1024,
    parameter int CAL_LOG2    = 4,
    parameter int FUSION_STEP = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic signed [RATE_W-1:0] ptch_rt,
    input  logic signed [INC_W-1:0]  ptch_acc,
    input  logic                     recal,
    output logic signed [INC_W-1:0]  incline,
    output logic                     incline_vld,
    output logic                     cal_done
);

    localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W  = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
    localparam int SUM_W  = RATE_W + CAL_LOG2;

    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CAL_LAST    = CNT_W'((1 << CAL_LOG2) - 1);

    state_e                    state_q;
    logic [SCNT_W-1:0]         settle_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [RATE_W-1:0]  offset_q;
    logic signed [INTEG_W-1:0] integ_q;
    logic signed [INC_W-1:0]   incline_q;
    logic                      incline_vld_q;
    logic                      cal_done_q;

    logic signed [SUM_W-1:0]   sum_d;
    logic signed [RATE_W:0]    rate_comp;
    logic signed [INTEG_W-1:0] neg_rate;
    logic signed [INTEG_W-1:0] fusion;
    logic signed [INTEG_W-1:0] integ_d;

    assign sum_d     = sum_q + SUM_W'(ptch_rt);
    assign rate_comp = (RATE_W + 1)'(ptch_rt) - (RATE_W + 1)'(offset_q);
    assign neg_rate  = -INTEG_W'(rate_comp);

    // Correction is judged against the last published incline, not the raw integrator.
    always_comb begin
        fusion = '0;
        if (ptch_acc > incline_q)      fusion = INTEG_W'(FUSION_STEP);
        else if (ptch_acc < incline_q) fusion = -INTEG_W'(FUSION_STEP);
    end

    sat_add27 u_sat (
        .a_i (integ_q),
        .b_i (neg_rate),
        .c_i (fusion),
        .y_o (integ_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SETTLE;
            settle_q      <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            offset_q      <= '0;
            integ_q       <= '0;
            incline_q     <= '0;
            incline_vld_q <= 1'b0;
            cal_done_q    <= 1'b0;
        end else begin
            incline_vld_q <= 1'b0;
            case (state_q)
                SETTLE: begin
                    settle_q <= settle_q + 1'b1;
                    if (settle_q == SETTLE_LAST) state_q <= CAL;
                end
                CAL: begin
                    if (vld) begin
                        if (cnt_q == CAL_LAST) begin
                            offset_q   <= RATE_W'(sum_d >>> CAL_LOG2);
                            sum_q      <= '0;
                            cnt_q      <= '0;
                            cal_done_q <= 1'b1;
                            state_q    <= RUN;
                        end else begin
                            sum_q <= sum_d;
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // recal outranks a coincident sample; offset survives until the new one lands.
                    if (recal) begin
                        integ_q    <= '0;
                        incline_q  <= '0;
                        sum_q      <= '0;
                        cnt_q      <= '0;
                        cal_done_q <= 1'b0;
                        state_q    <= CAL;
                    end else if (vld) begin
                        integ_q       <= integ_d;
                        incline_q     <= integ_d[INTEG_W-1 -: INC_W];
                        incline_vld_q <= 1'b1;
                    end
                end
                default: state_q <= SETTLE;
            endcase
        end
    end

    assign incline     = incline_q;
    assign incline_vld = incline_vld_q;
    assign cal_done    = cal_done_q;

endmodule
